// File: rtl/yapp_pkg.sv
// Shared YAPP definitions: transmitter states, field widths, command payload
// and header packing. Also imported by the router bench models.
package yapp_pkg;

    localparam int unsigned YAPP_MAX_LEN = 63;
    localparam int unsigned YAPP_ADDR_W  = 2;
    localparam int unsigned YAPP_LEN_W   = 6;
    localparam int unsigned YAPP_BYTE_W  = 8;
    localparam int unsigned YAPP_GAP_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } yapp_tx_state_e;

    // Launch parameters latched when a command is accepted
    typedef struct packed {
        logic                   bad_parity;
        logic [YAPP_LEN_W-1:0]  len;
        logic [YAPP_ADDR_W-1:0] addr;
    } yapp_cmd_t;

    function automatic logic [YAPP_BYTE_W-1:0] yapp_hdr(
        input logic [YAPP_ADDR_W-1:0] addr,
        input logic [YAPP_LEN_W-1:0]  len
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/yapp_tx_payload_buf.sv
// 64-byte payload store: one synchronous write port, one combinational read
// port. Contents are intentionally not reset.
module yapp_tx_payload_buf
    import yapp_pkg::*;
(
    input  logic                   clock,
    input  logic                   wr_en,
    input  logic [YAPP_LEN_W-1:0]  wr_addr,
    input  logic [YAPP_BYTE_W-1:0] wr_data,
    input  logic [YAPP_LEN_W-1:0]  rd_addr,
    output logic [YAPP_BYTE_W-1:0] rd_data_c
);

    logic [YAPP_BYTE_W-1:0] mem [0:YAPP_MAX_LEN];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/yapp_pkt_tx.sv
// YAPP packet transmitter: header, payload and parity bytes onto the router
// input channel with suspend back-pressure and a minimum inter-packet gap.
module yapp_pkt_tx
    import yapp_pkg::*;
#(
    parameter int unsigned MIN_GAP = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pl_wr_en,
    input  logic [YAPP_LEN_W-1:0]  pl_wr_addr,
    input  logic [YAPP_BYTE_W-1:0] pl_wr_data,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [YAPP_ADDR_W-1:0] cmd_addr,
    input  logic [YAPP_LEN_W-1:0]  cmd_len,
    input  logic                   cmd_bad_parity,
    output logic [YAPP_BYTE_W-1:0] in_data,
    output logic                   in_data_vld,
    input  logic                   in_suspend,
    output logic                   busy,
    output logic                   pkt_done,
    output logic [CNT_W-1:0]       pkt_cnt
);

    yapp_tx_state_e         state_q, state_d;
    yapp_cmd_t              cmd_q, cmd_d;
    logic [YAPP_LEN_W-1:0]  idx_q, idx_d;
    logic [YAPP_GAP_W-1:0]  gap_q, gap_d;
    logic [YAPP_BYTE_W-1:0] acc_q, acc_d;
    logic [YAPP_BYTE_W-1:0] data_d;
    logic                   vld_d;
    logic                   done_d;
    logic [CNT_W-1:0]       cnt_d;

    logic                   accept_c;
    logic                   buf_wr_en_c;
    logic [YAPP_LEN_W-1:0]  rd_addr_c;
    logic [YAPP_BYTE_W-1:0] rd_data_c;

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign accept_c    = in_data_vld && !in_suspend;
    assign buf_wr_en_c = pl_wr_en && !busy;

    // Read port looks one byte ahead so the next byte is ready on acceptance
    assign rd_addr_c = (state_q == ST_PAYLOAD) ? YAPP_LEN_W'(idx_q + YAPP_LEN_W'(1))
                                               : '0;

    yapp_tx_payload_buf u_payload_buf (
        .clock     (clock),
        .wr_en     (buf_wr_en_c),
        .wr_addr   (pl_wr_addr),
        .wr_data   (pl_wr_data),
        .rd_addr   (rd_addr_c),
        .rd_data_c (rd_data_c)
    );

    // Next-state and next-output decode
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        acc_d   = acc_q;
        data_d  = in_data;
        vld_d   = in_data_vld;
        done_d  = 1'b0;
        cnt_d   = pkt_cnt;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_HEADER;
                    cmd_d   = '{bad_parity: cmd_bad_parity, len: cmd_len, addr: cmd_addr};
                    acc_d   = '0;
                    idx_d   = '0;
                    data_d  = yapp_hdr(cmd_addr, cmd_len);
                    vld_d   = 1'b1;
                end
            end
            ST_HEADER: begin
                if (accept_c) begin
                    acc_d = acc_q ^ in_data;
                    idx_d = '0;
                    if (cmd_q.len != '0) begin
                        state_d = ST_PAYLOAD;
                        data_d  = rd_data_c;
                    end else begin
                        state_d = ST_PARITY;
                        data_d  = acc_d ^ {YAPP_BYTE_W{cmd_q.bad_parity}};
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept_c) begin
                    acc_d = acc_q ^ in_data;
                    if (idx_q == YAPP_LEN_W'(cmd_q.len - YAPP_LEN_W'(1))) begin
                        state_d = ST_PARITY;
                        data_d  = acc_d ^ {YAPP_BYTE_W{cmd_q.bad_parity}};
                    end else begin
                        idx_d  = YAPP_LEN_W'(idx_q + YAPP_LEN_W'(1));
                        data_d = rd_data_c;
                    end
                end
            end
            ST_PARITY: begin
                if (accept_c) begin
                    state_d = ST_GAP;
                    gap_d   = YAPP_GAP_W'(MIN_GAP);
                    vld_d   = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = CNT_W'(pkt_cnt + CNT_W'(1));
                end
            end
            ST_GAP: begin
                gap_d = YAPP_GAP_W'(gap_q - YAPP_GAP_W'(1));
                if (gap_q <= YAPP_GAP_W'(1)) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset truncates any packet in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            acc_q       <= '0;
            in_data     <= '0;
            in_data_vld <= 1'b0;
            pkt_done    <= 1'b0;
            pkt_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            acc_q       <= acc_d;
            in_data     <= data_d;
            in_data_vld <= vld_d;
            pkt_done    <= done_d;
            pkt_cnt     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_yapp_pkt_tx.sv
// Self-checking bench for yapp_pkt_tx: directed packets from the test plan plus
// randomized packets with random suspend, checked against a byte-level model.
module tb_yapp_pkt_tx;
    import yapp_pkg::*;

    localparam int unsigned TB_MIN_GAP = 2;
    localparam int unsigned TB_CNT_W   = 4;
    localparam int          CNT_MOD    = 1 << TB_CNT_W;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                pl_wr_en = 1'b0;
    logic [5:0]          pl_wr_addr = '0;
    logic [7:0]          pl_wr_data = '0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [1:0]          cmd_addr = '0;
    logic [5:0]          cmd_len = '0;
    logic                cmd_bad_parity = 1'b0;
    logic [7:0]          in_data;
    logic                in_data_vld;
    logic                in_suspend = 1'b0;
    logic                busy;
    logic                pkt_done;
    logic [TB_CNT_W-1:0] pkt_cnt;

    yapp_pkt_tx #(.MIN_GAP(TB_MIN_GAP), .CNT_W(TB_CNT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .pl_wr_en       (pl_wr_en),
        .pl_wr_addr     (pl_wr_addr),
        .pl_wr_data     (pl_wr_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_bad_parity (cmd_bad_parity),
        .in_data        (in_data),
        .in_data_vld    (in_data_vld),
        .in_suspend     (in_suspend),
        .busy           (busy),
        .pkt_done       (pkt_done),
        .pkt_cnt        (pkt_cnt)
    );

    initial forever #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_m [64];
    logic [7:0] exp_q[$];
    int         exp_cnt = 0;

    logic [7:0] acc_log[$];
    logic [7:0] vld_log[$];
    int         run_log[$];
    int         gap_log[$];
    int         done_cnt = 0;

    int susp_mode = 0;
    int susp_hold = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Channel monitor: logs valid/accepted bytes, run lengths and idle gaps
    initial begin
        logic       prev_vld  = 1'b0;
        logic       prev_susp = 1'b0;
        logic [7:0] prev_data = '0;
        logic       seen_vld  = 1'b0;
        int         run = 0;
        int         idle = 0;
        forever begin
            @(negedge clock);
            if (reset && prev_vld && prev_susp) begin
                check("susp_hold_vld", int'(in_data_vld), 1);
                check("susp_hold_data", int'(in_data), int'(prev_data));
            end
            if (in_data_vld) begin
                vld_log.push_back(in_data);
                if (!prev_vld && seen_vld) gap_log.push_back(idle);
                idle = 0;
                run++;
                seen_vld = 1'b1;
                if (!in_suspend) acc_log.push_back(in_data);
            end else begin
                if (prev_vld) run_log.push_back(run);
                run = 0;
                idle++;
            end
            if (pkt_done) done_cnt++;
            prev_vld  = reset ? in_data_vld : 1'b0;
            prev_susp = in_suspend;
            prev_data = in_data;
        end
    end

    // Suspend driver: off, random, or a 3-cycle stall on byte 0x33
    initial forever begin
        @(posedge clock);
        #1;
        case (susp_mode)
            1: in_suspend = ($urandom_range(0, 2) == 0);
            2: begin
                if (in_data_vld && in_data == 8'h33 && susp_hold < 3) begin
                    in_suspend = 1'b1;
                    susp_hold++;
                end else begin
                    in_suspend = 1'b0;
                end
            end
            default: in_suspend = 1'b0;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_buf(input int a, input logic [7:0] d);
        pl_wr_en   = 1'b1;
        pl_wr_addr = 6'(a);
        pl_wr_data = d;
        mem_m[a]   = d;
        step();
        pl_wr_en   = 1'b0;
    endtask

    // Model: header = len*4+addr, payload from buffer, parity = XOR of all, inverted if bad
    task automatic build_exp(input logic [1:0] a, input logic [5:0] l, input logic b);
        logic [7:0] par;
        exp_q.delete();
        exp_q.push_back(8'(int'(l) * 4 + int'(a)));
        par = exp_q[0];
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back(mem_m[i]);
            par = par ^ mem_m[i];
        end
        if (b) par = par ^ 8'hFF;
        exp_q.push_back(par);
    endtask

    task automatic launch(input logic [1:0] a, input logic [5:0] l, input logic b);
        int n = 0;
        cmd_addr       = a;
        cmd_len        = l;
        cmd_bad_parity = b;
        cmd_valid      = 1'b1;
        while (!cmd_ready && n < 50) begin step(); n++; end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic send_pkt(input string name, input logic [1:0] a, input logic [5:0] l,
                            input logic b);
        int n = 0;
        int d0;
        build_exp(a, l, b);
        acc_log.delete();
        vld_log.delete();
        d0 = done_cnt;
        launch(a, l, b);
        while (!pkt_done && n < 1000) begin step(); n++; end
        check({name, "_done_seen"}, int'(pkt_done), 1);
        exp_cnt++;
        check({name, "_pkt_cnt"}, int'(pkt_cnt), exp_cnt % CNT_MOD);
        repeat (TB_MIN_GAP + 2) step();
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_nbytes"}, acc_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++)
            check($sformatf("%s_b%0d", name, i), int'(acc_log[i]), int'(exp_q[i]));
    endtask

    initial begin
        int n;
        int d0;

        // Reset state
        #12;
        check("rst_in_data", int'(in_data), 0);
        check("rst_vld", int'(in_data_vld), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(pkt_done), 0);
        check("rst_cnt", int'(pkt_cnt), 0);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        @(negedge clock);
        reset = 1'b1;
        step();

        for (int i = 0; i < 64; i++) write_buf(i, 8'($urandom));
        write_buf(0, 8'h11);
        write_buf(1, 8'h22);
        write_buf(2, 8'h33);
        write_buf(3, 8'h44);

        // Basic packet
        send_pkt("basic", 2'd1, 6'd4, 1'b0);
        check("basic_hdr", int'(acc_log[0]), 8'h11);
        check("basic_parity", int'(acc_log[5]), 8'h55);
        check("basic_vld_cycles", vld_log.size(), 6);

        // Suspend held 3 cycles on 0x33
        susp_hold = 0;
        susp_mode = 2;
        send_pkt("susp", 2'd1, 6'd4, 1'b0);
        susp_mode = 0;
        check("susp_33_cycles", vld_log.find(x) with (x == 8'h33).size(), 4);
        check("susp_parity", int'(acc_log[5]), 8'h55);

        // Bad parity
        send_pkt("badpar", 2'd1, 6'd4, 1'b1);
        check("badpar_parity", int'(acc_log[5]), 8'hAA);

        // Zero-length
        send_pkt("len0", 2'd2, 6'd0, 1'b0);
        check("len0_hdr", int'(acc_log[0]), 8'h02);
        check("len0_parity", int'(acc_log[1]), 8'h02);
        check("len0_vld_cycles", vld_log.size(), 2);

        // Back-to-back max-length packets with buffer writes while busy
        build_exp(2'd3, 6'd63, 1'b0);
        acc_log.delete();
        vld_log.delete();
        run_log.delete();
        gap_log.delete();
        d0 = done_cnt;
        cmd_addr       = 2'd3;
        cmd_len        = 6'd63;
        cmd_bad_parity = 1'b0;
        cmd_valid      = 1'b1;
        n = 0;
        while (done_cnt - d0 < 2 && n < 400) begin
            if ((n >= 3 && n < 60) || (n >= 75 && n < 125)) begin
                pl_wr_en   = 1'b1;
                pl_wr_addr = 6'($urandom);
                pl_wr_data = 8'($urandom);
            end else begin
                pl_wr_en = 1'b0;
            end
            step();
            n++;
        end
        cmd_valid = 1'b0;
        pl_wr_en  = 1'b0;
        exp_cnt += 2;
        repeat (TB_MIN_GAP + 4) step();
        check("b2b_done_pulses", done_cnt - d0, 2);
        check("b2b_pkt_cnt", int'(pkt_cnt), exp_cnt % CNT_MOD);
        check("b2b_idle_after", int'(busy), 0);
        check("b2b_hdr", int'(acc_log[0]), 8'hFF);
        check("b2b_nbytes", acc_log.size(), 130);
        check("b2b_runs", run_log.size(), 2);
        check("b2b_run0", run_log[0], 65);
        check("b2b_run1", run_log[1], 65);
        check("b2b_gap", gap_log[gap_log.size() - 1], TB_MIN_GAP + 1);
        for (int i = 0; i < 65; i++) begin
            check($sformatf("b2b_p0_b%0d", i), int'(acc_log[i]), int'(exp_q[i]));
            check($sformatf("b2b_p1_b%0d", i), int'(acc_log[65 + i]), int'(exp_q[i]));
        end

        // Randomized packets with random suspend; counter wraps along the way
        for (int k = 0; k < 14; k++) begin
            logic [1:0] a;
            logic [5:0] l;
            logic       b;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 8)) write_buf(int'($urandom_range(0, 63)), 8'($urandom));
            end
            a = 2'($urandom);
            l = 6'($urandom);
            b = ($urandom_range(0, 3) == 0);
            susp_mode = 1;
            send_pkt($sformatf("rnd%0d", k), a, l, b);
            susp_mode = 0;
            step();
        end

        // Reset while payload byte 10 is on the channel
        build_exp(2'd1, 6'd20, 1'b0);
        acc_log.delete();
        launch(2'd1, 6'd20, 1'b0);
        n = 0;
        while (acc_log.size() < 11 && n < 100) begin step(); n++; end
        check("rstmid_byte10", int'(in_data), int'(exp_q[11]));
        d0 = done_cnt;
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_vld_async", int'(in_data_vld), 0);
        check("rstmid_busy", int'(busy), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        step();
        exp_cnt = 0;
        check("rstmid_cmd_ready", int'(cmd_ready), 1);
        check("rstmid_pkt_cnt", int'(pkt_cnt), exp_cnt);
        repeat (5) step();
        check("rstmid_no_done", done_cnt - d0, 0);
        check("rstmid_vld_idle", int'(in_data_vld), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
